// File: rtl/fma16_sched_pkg.sv
// Shared types for the fma16 scheduler: issued operation, tagged response
// and flag bit positions within the 4-bit flags field.
package fma16_sched_pkg;

  localparam int ID_MAXW = 3;

  localparam int FLAG_INEXACT   = 0;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_INVALID   = 3;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;
    logic        mul;
    logic        add;
    logic        negp;
    logic        negz;
    logic [1:0]  rm;
  } fma_op_t;

  typedef struct packed {
    logic [15:0]        result;
    logic [3:0]         flags;
    logic [ID_MAXW-1:0] id;
  } fma_rsp_t;

endpackage

// File: rtl/fma16_rspq.sv
// Show-ahead response FIFO; push and pop may coincide at any fill level,
// a pop on an empty queue is ignored.
module fma16_rspq
  import fma16_sched_pkg::*;
#(
  parameter int DEPTH = 5,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  fma_rsp_t      wdata,
  input  logic          pop,
  output fma_rsp_t      rdata,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fma_rsp_t        mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
    !(push && full && !pop));

endmodule

// File: rtl/fma16_sched.sv
// Round-robin front end for a shared pipelined fma16 datapath: arbitrates
// requesters, tracks IDs through the datapath and returns tagged results.
module fma16_sched
  import fma16_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int LAT  = 3,
  parameter int RSPQ = LAT + 2,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*16-1:0] req_x,
  input  logic [NREQ*16-1:0] req_y,
  input  logic [NREQ*16-1:0] req_z,
  input  logic [NREQ-1:0]   req_mul,
  input  logic [NREQ-1:0]   req_add,
  input  logic [NREQ-1:0]   req_negp,
  input  logic [NREQ-1:0]   req_negz,
  input  logic [NREQ*2-1:0] req_rm,
  output logic              dp_issue,
  output logic [15:0]       dp_x,
  output logic [15:0]       dp_y,
  output logic [15:0]       dp_z,
  output logic              dp_mul,
  output logic              dp_add,
  output logic              dp_negp,
  output logic              dp_negz,
  output logic [1:0]        dp_rm,
  input  logic [15:0]       dp_result,
  input  logic [3:0]        dp_flags,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [15:0]       rsp_result,
  output logic [3:0]        rsp_flags,
  output logic [IDW-1:0]    rsp_id,
  output logic              busy
);

  localparam int QCW = $clog2(RSPQ + 1);
  localparam int OCW = 8;
  // The issue register is the first of the LAT datapath cycles, so only
  // LAT-1 tag stages follow it.
  localparam int TS  = (LAT > 1) ? LAT - 1 : 1;
  localparam logic [OCW-1:0] RSPQ_O = OCW'(RSPQ);

  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] gnt_id;
  logic           gnt_found;
  logic           credit_ok;
  logic           accept;
  logic           pop_now;
  logic [OCW-1:0] occ;

  logic           issue_v;
  logic [IDW-1:0] issue_id;
  fma_op_t        issue_op;
  fma_op_t        sel_op;

  logic [TS-1:0]  tag_v;
  logic [IDW-1:0] tag_id [TS];
  logic           last_v;
  logic [IDW-1:0] last_id;

  fma_rsp_t       q_wdata;
  fma_rsp_t       q_rdata;
  logic [QCW-1:0] q_count;
  logic           q_empty;
  logic           q_full;
  logic           unused_bits;

  always_comb begin
    occ = {{(OCW-1){1'b0}}, issue_v};
    for (int i = 0; i < TS; i++) occ = occ + {{(OCW-1){1'b0}}, tag_v[i]};
    occ = occ + OCW'(q_count);
  end

  assign pop_now   = rsp_valid && rsp_ready;
  assign credit_ok = (occ < RSPQ_O) || ((occ == RSPQ_O) && pop_now);

  always_comb begin
    int idx;
    idx       = 0;
    gnt_found = 1'b0;
    gnt_id    = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!gnt_found && req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_id    = IDW'(idx);
      end
    end
  end

  assign accept    = gnt_found && credit_ok && reset;
  assign req_ready = accept ? (NREQ'(1) << gnt_id) : '0;

  always_comb begin
    sel_op      = '0;
    sel_op.x    = req_x[16*int'(gnt_id) +: 16];
    sel_op.y    = req_y[16*int'(gnt_id) +: 16];
    sel_op.z    = req_z[16*int'(gnt_id) +: 16];
    sel_op.mul  = req_mul[gnt_id];
    sel_op.add  = req_add[gnt_id];
    sel_op.negp = req_negp[gnt_id];
    sel_op.negz = req_negz[gnt_id];
    sel_op.rm   = req_rm[2*int'(gnt_id) +: 2];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr   <= '0;
      issue_v  <= 1'b0;
      issue_id <= '0;
      issue_op <= '0;
    end else begin
      issue_v <= accept;
      if (accept) begin
        issue_op <= sel_op;
        issue_id <= gnt_id;
        rr_ptr   <= (int'(gnt_id) == NREQ - 1) ? '0 : gnt_id + IDW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_v <= '0;
      for (int i = 0; i < TS; i++) tag_id[i] <= '0;
    end else begin
      tag_v[0]  <= issue_v && (LAT > 1);
      tag_id[0] <= issue_id;
      for (int i = 1; i < TS; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end
    end
  end

  assign last_v  = (LAT == 1) ? issue_v  : tag_v[TS-1];
  assign last_id = (LAT == 1) ? issue_id : tag_id[TS-1];

  always_comb begin
    q_wdata             = '0;
    q_wdata.result      = dp_result;
    q_wdata.flags       = dp_flags;
    q_wdata.id[IDW-1:0] = last_id;
  end

  fma16_rspq #(.DEPTH(RSPQ), .CW(QCW)) u_rspq (
    .clk   (clk),
    .reset (reset),
    .push  (last_v),
    .wdata (q_wdata),
    .pop   (rsp_ready),
    .rdata (q_rdata),
    .count (q_count),
    .empty (q_empty),
    .full  (q_full)
  );

  assign dp_issue = issue_v;
  assign dp_x     = issue_op.x;
  assign dp_y     = issue_op.y;
  assign dp_z     = issue_op.z;
  assign dp_mul   = issue_op.mul;
  assign dp_add   = issue_op.add;
  assign dp_negp  = issue_op.negp;
  assign dp_negz  = issue_op.negz;
  assign dp_rm    = issue_op.rm;

  // Head data is masked while empty so stale slots never reach the outputs.
  assign rsp_valid  = !q_empty;
  assign rsp_result = rsp_valid ? q_rdata.result : '0;
  assign rsp_flags  = rsp_valid ? q_rdata.flags : '0;
  assign rsp_id     = rsp_valid ? q_rdata.id[IDW-1:0] : '0;
  assign busy       = (occ != '0);

  assign unused_bits = ^{q_full, q_rdata.id};

endmodule

// File: tb/tb_fma16_sched.sv
// Scoreboard bench for fma16_sched with a behavioural fixed-latency datapath.
module tb_fma16_sched;
  import fma16_sched_pkg::*;

  localparam int NREQ = 4;
  localparam int LAT  = 3;
  localparam int RSPQ = LAT + 2;
  localparam int IDW  = 2;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic [NREQ-1:0]    req_valid, req_ready;
  logic [NREQ*16-1:0] req_x, req_y, req_z;
  logic [NREQ-1:0]    req_mul, req_add, req_negp, req_negz;
  logic [NREQ*2-1:0]  req_rm;
  logic               dp_issue, dp_mul, dp_add, dp_negp, dp_negz;
  logic [15:0]        dp_x, dp_y, dp_z, dp_result;
  logic [1:0]         dp_rm;
  logic [3:0]         dp_flags;
  logic               rsp_valid, rsp_ready, busy;
  logic [15:0]        rsp_result;
  logic [3:0]         rsp_flags;
  logic [IDW-1:0]     rsp_id;

  logic [15:0] opx [NREQ];
  logic [15:0] opy [NREQ];
  logic [15:0] opz [NREQ];
  logic [1:0]  oprm [NREQ];

  always #5 clk = ~clk;

  always_comb begin
    req_x = '0; req_y = '0; req_z = '0; req_rm = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_x[16*i +: 16] = opx[i];
      req_y[16*i +: 16] = opy[i];
      req_z[16*i +: 16] = opz[i];
      req_rm[2*i +: 2]  = oprm[i];
    end
  end

  fma16_sched #(.NREQ(NREQ), .LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_z(req_z),
    .req_mul(req_mul), .req_add(req_add), .req_negp(req_negp), .req_negz(req_negz),
    .req_rm(req_rm),
    .dp_issue(dp_issue), .dp_x(dp_x), .dp_y(dp_y), .dp_z(dp_z),
    .dp_mul(dp_mul), .dp_add(dp_add), .dp_negp(dp_negp), .dp_negz(dp_negz),
    .dp_rm(dp_rm), .dp_result(dp_result), .dp_flags(dp_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_id(rsp_id),
    .busy(busy)
  );

  function automatic logic [19:0] dp_model(input logic [15:0] x, y, z,
                                           input logic mul, add, negp, negz,
                                           input logic [1:0] rm);
    logic [15:0] r;
    logic [3:0]  f;
    if (x == 16'h3C00 && y == 16'h4000 && z == 16'h3C00 && mul && add &&
        !negp && !negz && rm == 2'd0)
      r = 16'h4200;
    else
      r = (x + y) ^ z ^ {10'd0, rm, negz, negp, add, mul};
    f = x[3:0] ^ y[3:0] ^ z[3:0];
    f[FLAG_INVALID] = f[FLAG_INVALID] ^ negp;
    return {f, r};
  endfunction

  // Result emerges LAT-1 cycles after the dp_issue cycle; not reset on purpose.
  logic [19:0] dpp [LAT-1];
  always @(posedge clk) begin
    dpp[0] <= dp_issue ? dp_model(dp_x, dp_y, dp_z, dp_mul, dp_add, dp_negp, dp_negz, dp_rm)
                       : 20'hBAD55;
    for (int i = 1; i < LAT - 1; i++) dpp[i] <= dpp[i-1];
  end
  assign dp_result = dpp[LAT-2][15:0];
  assign dp_flags  = dpp[LAT-2][19:16];

  typedef struct {
    logic [15:0] res;
    logic [3:0]  flg;
    int          id;
    int          rdy;
  } sb_t;

  sb_t sb[$];
  int  grants[$];
  int  n_chk = 0, n_pass = 0, cyc = 0, exp_ptr = 0;
  logic [NREQ-1:0] refill = '0;
  logic [NREQ-1:0] s_acc;
  int          s_nacc, s_id;
  logic        s_rv;
  logic [15:0] s_res;
  logic [3:0]  s_flg;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic new_op(input int i);
    opx[i] = 16'($urandom); opy[i] = 16'($urandom); opz[i] = 16'($urandom);
    oprm[i] = 2'($urandom);
    req_mul[i] = 1'($urandom); req_add[i] = 1'($urandom);
    req_negp[i] = 1'($urandom); req_negz[i] = 1'($urandom);
    req_valid[i] = 1'b1;
  endtask

  // One clock: check against the model mid-cycle, then update requesters after the edge.
  task automatic step();
    logic [NREQ-1:0] exp_rdy;
    logic            exp_rv, exp_pop;
    logic [19:0]     m;
    int              occ, idx;
    sb_t             e;
    @(negedge clk);
    occ     = sb.size();
    exp_rv  = (occ > 0) && (sb[0].rdy <= cyc);
    exp_pop = exp_rv && rsp_ready;
    exp_rdy = '0;
    if (occ < RSPQ || (occ == RSPQ && exp_pop))
      for (int k = 0; k < NREQ; k++) begin
        idx = (exp_ptr + k) % NREQ;
        if (exp_rdy == '0 && req_valid[idx]) exp_rdy[idx] = 1'b1;
      end
    check_eq("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
    check_eq("req_ready", 32'(req_ready), 32'(exp_rdy));
    check_eq("busy", 32'(busy), 32'(occ != 0));
    s_rv = rsp_valid; s_res = rsp_result; s_flg = rsp_flags; s_id = int'(rsp_id);
    if (rsp_valid && rsp_ready) begin
      check_eq("sb_has_entry", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check_eq("rsp_result", 32'(rsp_result), 32'(e.res));
        check_eq("rsp_flags", 32'(rsp_flags), 32'(e.flg));
        check_eq("rsp_id", 32'(rsp_id), 32'(e.id));
      end
    end
    s_acc  = req_valid & req_ready;
    s_nacc = $countones(s_acc);
    for (int g = 0; g < NREQ; g++)
      if (s_acc[g]) begin
        m = dp_model(opx[g], opy[g], opz[g], req_mul[g], req_add[g], req_negp[g],
                     req_negz[g], oprm[g]);
        sb.push_back('{m[15:0], m[19:16], g, cyc + LAT + 1});
        exp_ptr = (g + 1) % NREQ;
        grants.push_back(g);
      end
    cyc++;
    @(posedge clk); #1;
    for (int i = 0; i < NREQ; i++)
      if (s_acc[i]) begin
        if (refill[i]) new_op(i);
        else req_valid[i] = 1'b0;
      end
  endtask

  task automatic drain();
    refill = '0; req_valid = '0; rsp_ready = 1'b1;
    for (int n = 0; n < 40 && (sb.size() != 0 || busy); n++) step();
    check_eq("drained", 32'(sb.size()), 32'd0);
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    sb.delete(); exp_ptr = 0;
  endtask

  int total, n, waited;
  logic prev1, twice1;

  initial begin
    for (int i = 0; i < NREQ; i++) new_op(i);
    rsp_ready = 1'b0;
    #12;
    check_eq("rst_dp_issue", 32'(dp_issue), 32'd0);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_req_ready", 32'(req_ready), 32'd0);
    check_eq("rst_dp_x", 32'(dp_x), 32'd0);
    req_valid = '0;
    @(posedge clk); #1;
    reset = 1'b1;

    // Single op on requester 2, 1.0*2.0+1.0
    rsp_ready = 1'b1;
    opx[2] = 16'h3C00; opy[2] = 16'h4000; opz[2] = 16'h3C00; oprm[2] = 2'd0;
    req_mul[2] = 1'b1; req_add[2] = 1'b1; req_negp[2] = 1'b0; req_negz[2] = 1'b0;
    req_valid[2] = 1'b1;
    step();
    check_eq("t1_grant", 32'(s_acc), 32'h4);
    n = 0;
    do begin step(); n++; end while (!s_rv && n < 12);
    check_eq("t1_latency", 32'(n), 32'd4);
    check_eq("t1_id", 32'(s_id), 32'd2);
    check_eq("t1_result", 32'(s_res), 32'h4200);
    check_eq("t1_flags", 32'(s_flg), 32'd0);
    drain();

    // All requesters busy, free-flowing responses
    pulse_reset();
    grants.delete();
    refill = '1;
    for (int i = 0; i < NREQ; i++) new_op(i);
    repeat (6) step();
    check_eq("t2_ngrants", 32'(grants.size()), 32'd6);
    for (int i = 0; i < 6 && i < grants.size(); i++)
      check_eq("t2_order", 32'(grants[i]), 32'(i % NREQ));
    total = 0;
    repeat (10) begin step(); total += int'(s_rv); end
    check_eq("t2_rsp_continuous", 32'(total), 32'd10);
    drain();

    // Back-pressure: credits run out at RSPQ
    rsp_ready = 1'b0; refill = '1;
    for (int i = 0; i < NREQ; i++) new_op(i);
    total = 0;
    repeat (12) begin step(); total += s_nacc; end
    check_eq("t3_accepts", 32'(total), 32'(RSPQ));
    rsp_ready = 1'b1;
    step();
    check_eq("t3_pop_admit", 32'(s_nacc), 32'd1);
    rsp_ready = 1'b0;
    total = 0;
    repeat (3) begin step(); total += s_nacc; end
    check_eq("t3_hold", 32'(total), 32'd0);

    // Saturated queue with simultaneous push and pop
    rsp_ready = 1'b1;
    total = 0;
    repeat (16) begin step(); total += s_nacc; end
    check_eq("t6_busy", 32'(busy), 32'd1);
    check_eq("t6_some_accepts", 32'(total >= 8), 32'd1);
    drain();

    // Fairness: requester 3 joins a stream from requester 1
    rsp_ready = 1'b1; refill = 4'b0010;
    new_op(1);
    repeat (3 + $urandom_range(0, 3)) step();
    new_op(3);
    waited = 0; prev1 = 1'b0; twice1 = 1'b0;
    while (req_valid[3] && waited < 3 * NREQ) begin
      step(); waited++;
      if (s_acc[1] && prev1) twice1 = 1'b1;
      prev1 = s_acc[1];
    end
    check_eq("t4_wait", 32'(waited <= NREQ), 32'd1);
    check_eq("t4_no_double", 32'(twice1), 32'd0);
    drain();

    // Reset with three in flight and two queued
    rsp_ready = 1'b0; refill = '1;
    for (int i = 0; i < NREQ; i++) new_op(i);
    total = 0;
    for (int k = 0; k < 10 && total < RSPQ; k++) begin step(); total += s_nacc; end
    check_eq("t5_setup", 32'(total), 32'(RSPQ));
    reset = 1'b0;
    #1;
    check_eq("t5_dp_issue", 32'(dp_issue), 32'd0);
    check_eq("t5_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("t5_busy", 32'(busy), 32'd0);
    check_eq("t5_req_ready", 32'(req_ready), 32'd0);
    check_eq("t5_rsp_result", 32'(rsp_result), 32'd0);
    sb.delete(); exp_ptr = 0; refill = '0; req_valid = '0;
    new_op(0); new_op(3);
    @(posedge clk); #1;
    reset = 1'b1;
    rsp_ready = 1'b1;
    grants.delete();
    repeat (3) step();
    check_eq("t5_first_grant", 32'(grants.size() > 0 ? grants[0] : -1), 32'd0);
    check_eq("t5_second_grant", 32'(grants.size() > 1 ? grants[1] : -1), 32'd3);
    repeat (8) step();
    check_eq("t5_idle", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
